// File: rtl/sap_pkg.sv
// Shared SAP-1 sizing constants and the MAR/RAM loader state type.
package sap_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PROG = 2'd1,
    S_DONE = 2'd2
  } sap_state_t;

endpackage

// File: rtl/ram16x8.sv
// Program/data RAM: one synchronous write port, one asynchronous read port.
module ram16x8 #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mar_ram_unit.sv
// Memory address register plus RAM, with a streaming loader that fills every word.
module mar_ram_unit
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_W = sap_pkg::ADDR_W,
  parameter int unsigned DATA_W = sap_pkg::DATA_W,
  parameter int unsigned DEPTH  = sap_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              lm,
  input  logic              ce,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done
);

  sap_state_t        state, state_n;
  logic [ADDR_W-1:0] mar, mar_n;
  logic [ADDR_W-1:0] prog_ptr, prog_ptr_n;
  logic              we;
  logic [DATA_W-1:0] rdata;
  logic              unused_bus_hi;

  assign unused_bus_hi = ^bus_in[DATA_W-1:ADDR_W];

  always_comb begin
    state_n    = state;
    mar_n      = mar;
    prog_ptr_n = prog_ptr;
    we         = 1'b0;
    unique case (state)
      S_RUN: begin
        if (lm) mar_n = bus_in[ADDR_W-1:0];
        if (prog_mode) begin
          state_n    = S_PROG;
          prog_ptr_n = '0;
        end
      end
      S_PROG: begin
        // Dropping prog_mode aborts before any write in that same cycle.
        if (!prog_mode) begin
          state_n = S_RUN;
        end else if (prog_valid && prog_ready) begin
          we = 1'b1;
          if (prog_ptr == ADDR_W'(DEPTH - 1)) begin
            state_n    = S_DONE;
            prog_ptr_n = '0;
          end else begin
            prog_ptr_n = prog_ptr + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!prog_mode) state_n = S_RUN;
      end
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= S_RUN;
      mar        <= '0;
      prog_ptr   <= '0;
      prog_ready <= 1'b0;
      prog_done  <= 1'b0;
    end else begin
      state      <= state_n;
      mar        <= mar_n;
      prog_ptr   <= prog_ptr_n;
      prog_ready <= (state_n == S_PROG);
      prog_done  <= (state_n == S_DONE);
    end
  end

  ram16x8 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we && !clear),
    .waddr(prog_ptr),
    .wdata(prog_data),
    .raddr(mar),
    .rdata(rdata)
  );

  assign bus_out = (state == S_RUN && ce) ? rdata : 'z;

endmodule

// File: tb/tb_mar_ram_unit.sv
// Self-checking bench for mar_ram_unit: directed sequences, a vector table and random traffic.
module tb_mar_ram_unit;

  logic       clk = 1'b0;
  logic       clear, lm, ce, prog_mode, prog_valid;
  logic [7:0] bus_in, prog_data;
  wire  [7:0] bus_out;
  logic       prog_ready, prog_done;

  always #5 clk = ~clk;

  mar_ram_unit #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk       (clk),
    .clear     (clear),
    .lm        (lm),
    .ce        (ce),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .prog_mode (prog_mode),
    .prog_valid(prog_valid),
    .prog_data (prog_data),
    .prog_ready(prog_ready),
    .prog_done (prog_done)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain memory image plus loader session flags.
  byte unsigned m_ram [16];
  bit           m_known [16];
  int           m_mar, m_ptr;
  bit           m_prog, m_done;

  logic [7:0] last_bus;
  logic       last_ready, last_done;

  typedef struct {
    bit         lm;
    bit         ce;
    logic [7:0] bus_in;
    bit         en;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [8];

  // A released bus reads as z in 4-state simulation and as 0 in 2-state simulation.
  function automatic bit released(logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  task automatic check8(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_hiz(string name, logic [7:0] got);
    checks++;
    if (!released(got)) begin
      failures++;
      $display("FAIL %s got=%h exp=zz t=%0t", name, got, $time);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge with inputs already set.
  task automatic cycle();
    bit enabled;
    #3;
    last_bus   = bus_out;
    last_ready = prog_ready;
    last_done  = prog_done;
    check_int("prog_ready", int'(prog_ready), int'(m_prog));
    check_int("prog_done", int'(prog_done), int'(m_done));
    enabled = ce && !m_prog && !m_done;
    if (enabled) begin
      if (m_known[m_mar]) check8("bus_out", bus_out, m_ram[m_mar]);
    end else begin
      check_hiz("bus_out_hiz", bus_out);
    end
    @(posedge clk);
    if (clear) begin
      m_prog = 0; m_done = 0; m_mar = 0; m_ptr = 0;
    end else if (!m_prog && !m_done) begin
      if (lm) m_mar = int'(bus_in) % 16;
      if (prog_mode) begin
        m_prog = 1; m_ptr = 0;
      end
    end else if (!prog_mode) begin
      m_prog = 0; m_done = 0;
    end else if (m_prog && prog_valid) begin
      m_ram[m_ptr]   = prog_data;
      m_known[m_ptr] = 1;
      m_ptr++;
      if (m_ptr == 16) begin
        m_ptr = 0; m_prog = 0; m_done = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    clear = 0; lm = 0; ce = 0; prog_mode = 0; prog_valid = 0;
    bus_in = 8'h00; prog_data = 8'h00;
  endtask

  task automatic read_word(string name, int addr, logic [7:0] exp);
    idle(); lm = 1; bus_in = 8'(addr);
    cycle();
    idle(); ce = 1;
    cycle();
    ce = 0;
    check8(name, last_bus, exp);
  endtask

  int rdy_cycles;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h15};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 8'h03, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b1, 8'h07, 1'b1, 8'h13};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h17};
    tbl[6] = '{1'b1, 1'b1, 8'hFE, 1'b1, 8'h17};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h1E};

    for (int i = 0; i < 16; i++) m_known[i] = 0;
    m_mar = 0; m_ptr = 0; m_prog = 0; m_done = 0;

    // Power-up clear, unchecked until the DUT state is defined.
    idle(); clear = 1;
    @(posedge clk); @(posedge clk); #1;
    clear = 1;
    cycle();
    idle();
    cycle();
    check_int("reset_ready", int'(last_ready), 0);
    check_int("reset_done", int'(last_done), 0);

    // Stream a full program back-to-back.
    prog_mode = 1;
    cycle();
    check_int("entry_ready", int'(last_ready), 0);
    rdy_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      prog_valid = 1; prog_data = 8'(8'h10 + i);
      cycle();
      rdy_cycles += int'(last_ready);
    end
    prog_valid = 0;
    cycle();
    check_int("ready_count", rdy_cycles, 16);
    check_int("done_after_16", int'(last_done), 1);
    check_int("ready_in_done", int'(last_ready), 0);
    prog_valid = 1; prog_data = 8'h99;
    cycle();
    prog_mode = 0; prog_valid = 0;
    cycle();
    cycle();
    check_int("done_cleared", int'(last_done), 0);

    // Vector table: load/read ordering, including simultaneous lm and ce.
    for (int i = 0; i < 8; i++) begin
      idle();
      lm = tbl[i].lm; ce = tbl[i].ce; bus_in = tbl[i].bus_in;
      cycle();
      if (tbl[i].en) check8("tbl_bus", last_bus, tbl[i].exp);
      else           check_hiz("tbl_hiz", last_bus);
    end

    // Clear for two cycles with ce held: mar returns to 0.
    idle(); clear = 1; ce = 1;
    cycle();
    cycle();
    clear = 0;
    cycle();
    check8("reset_ram0", last_bus, 8'h10);
    check_int("reset_ready2", int'(last_ready), 0);

    // Abort after five bytes, with a byte offered in the abort cycle.
    idle(); prog_mode = 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      prog_valid = 1; prog_data = 8'hFF;
      cycle();
    end
    prog_mode = 0; prog_valid = 1; prog_data = 8'h55;
    cycle();
    idle();
    cycle();
    check_int("abort_ready", int'(last_ready), 0);
    read_word("abort_ram4", 4, 8'hFF);
    read_word("abort_ram5", 5, 8'h15);
    read_word("abort_ram0", 0, 8'hFF);

    // Re-entry restarts at word 0.
    idle(); prog_mode = 1;
    cycle();
    prog_valid = 1; prog_data = 8'h77;
    cycle();
    idle();
    cycle();
    read_word("reentry_ram0", 0, 8'h77);
    read_word("reentry_ram1", 1, 8'hFF);

    // Clear mid-program after three writes.
    idle(); prog_mode = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1; prog_data = 8'(8'hAA + 8'(i) * 8'h11);
      cycle();
    end
    clear = 1; prog_valid = 1; prog_data = 8'h99;
    cycle();
    idle();
    cycle();
    check_int("midclr_ready", int'(last_ready), 0);
    read_word("midclr_ram2", 2, 8'hCC);
    read_word("midclr_ram3", 3, 8'hFF);
    read_word("midclr_ram0", 0, 8'hAA);

    // Random traffic against the model.
    idle();
    for (int n = 0; n < 3000; n++) begin
      clear      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) prog_mode = ~prog_mode;
      lm         = 1'($urandom);
      ce         = 1'($urandom);
      prog_valid = ($urandom_range(0, 3) != 0);
      bus_in     = 8'($urandom);
      prog_data  = 8'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
